// File: rtl/imem_prefetch_queue.sv
// Instruction prefetch queue: issues sequential IMEM word requests ahead of Fetch and
// drops in-flight responses after a redirect. Optional counters under PREFETCH_STATS_EN.
module imem_prefetch_queue #(
    parameter int unsigned DEPTH        = 4,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirectValid,
    input  logic [31:0] redirectAddress,
    output logic        memRequest,
    output logic [31:0] memAddress,
    input  logic        memReady,
    input  logic        memDataValid,
    input  logic [31:0] memData,
    output logic        fetchValid,
    output logic [31:0] fetchInstruction,
    output logic [31:0] fetchProgramCounter,
    input  logic        fetchReady,
    output logic        protocolError
`ifdef PREFETCH_STATS_EN
    ,
    output logic [31:0] statFlushCount,
    output logic [31:0] statDropCount
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        SLOT_EMPTY  = 2'd0,
        SLOT_ALLOC  = 2'd1,
        SLOT_FILLED = 2'd2
    } slot_state_e;

    typedef struct packed {
        slot_state_e state;
        logic [31:0] pc;
        logic [31:0] instr;
    } slot_t;

    slot_t             slot_q [DEPTH];
    slot_t             slot_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [PTR_W-1:0]  fill_q, fill_d;
    logic [CNT_W-1:0]  occ_q, occ_d;
    logic [CNT_W-1:0]  alloc_q, alloc_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [31:0]       next_pc_q, next_pc_d;
    logic              perr_q, perr_d;

    logic              mem_fire;
    logic              pop;
    logic              fill_evt;
    logic              drop_evt;
    logic [CNT_W:0]    pending;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^redirectAddress[1:0];

    // Occupied slots plus responses still to be discarded bound the issue window.
    assign memRequest = reset && !redirectValid &&
                        ((CNT_W+1)'(occ_q) + (CNT_W+1)'(drop_q) < (CNT_W+1)'(DEPTH));
    assign memAddress          = next_pc_q;
    assign fetchValid          = (slot_q[head_q].state == SLOT_FILLED) && !redirectValid;
    assign fetchInstruction    = slot_q[head_q].instr;
    assign fetchProgramCounter = slot_q[head_q].pc;
    assign protocolError       = perr_q;

    assign mem_fire = memRequest && memReady;
    assign pop      = fetchValid && fetchReady;

    // Next-state: redirect flushes everything, otherwise issue / fill / pop in parallel.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) slot_d[i] = slot_q[i];
        head_d    = head_q;
        tail_d    = tail_q;
        fill_d    = fill_q;
        occ_d     = occ_q;
        alloc_d   = alloc_q;
        drop_d    = drop_q;
        next_pc_d = next_pc_q;
        perr_d    = perr_q;
        fill_evt  = 1'b0;
        drop_evt  = 1'b0;
        pending   = '0;

        if (redirectValid) begin
            for (int i = 0; i < int'(DEPTH); i++) slot_d[i].state = SLOT_EMPTY;
            head_d    = '0;
            tail_d    = '0;
            fill_d    = '0;
            occ_d     = '0;
            alloc_d   = '0;
            next_pc_d = {redirectAddress[31:2], 2'b00};
            pending   = (CNT_W+1)'(drop_q) + (CNT_W+1)'(alloc_q);
            if (memDataValid) begin
                if (pending != '0) begin
                    pending  = pending - (CNT_W+1)'(1);
                    drop_evt = 1'b1;
                end else begin
                    perr_d = 1'b1;
                end
            end
            drop_d = CNT_W'(pending);
        end else begin
            if (mem_fire) begin
                slot_d[tail_q].state = SLOT_ALLOC;
                slot_d[tail_q].pc    = next_pc_q;
                tail_d               = tail_q + PTR_W'(1);
                next_pc_d            = next_pc_q + 32'd4;
            end
            if (memDataValid) begin
                if (drop_q != '0) begin
                    drop_d   = drop_q - CNT_W'(1);
                    drop_evt = 1'b1;
                end else if (alloc_q != '0) begin
                    slot_d[fill_q].state = SLOT_FILLED;
                    slot_d[fill_q].instr = memData;
                    fill_d               = fill_q + PTR_W'(1);
                    fill_evt             = 1'b1;
                end else begin
                    perr_d = 1'b1;
                end
            end
            if (pop) begin
                slot_d[head_q].state = SLOT_EMPTY;
                head_d               = head_q + PTR_W'(1);
            end
            occ_d   = occ_q + CNT_W'(mem_fire) - CNT_W'(pop);
            alloc_d = alloc_q + CNT_W'(mem_fire) - CNT_W'(fill_evt);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) slot_q[i] <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            fill_q    <= '0;
            occ_q     <= '0;
            alloc_q   <= '0;
            drop_q    <= '0;
            next_pc_q <= RESET_VECTOR;
            perr_q    <= 1'b0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) slot_q[i] <= slot_d[i];
            head_q    <= head_d;
            tail_q    <= tail_d;
            fill_q    <= fill_d;
            occ_q     <= occ_d;
            alloc_q   <= alloc_d;
            drop_q    <= drop_d;
            next_pc_q <= next_pc_d;
            perr_q    <= perr_d;
        end
    end

`ifdef PREFETCH_STATS_EN
    logic [31:0] flush_cnt_q;
    logic [31:0] drop_cnt_q;

    // Saturating event counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flush_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (redirectValid && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 32'd1;
            if (drop_evt && (drop_cnt_q != '1))       drop_cnt_q  <= drop_cnt_q + 32'd1;
        end
    end

    assign statFlushCount = flush_cnt_q;
    assign statDropCount  = drop_cnt_q;
`else
    logic unused_drop_evt;
    assign unused_drop_evt = drop_evt;
`endif

endmodule

// File: tb/tb_imem_prefetch_queue.sv
// Bench for imem_prefetch_queue: fixed vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_imem_prefetch_queue;

    localparam int unsigned DEPTH = 4;

    logic        clock;
    logic        reset;
    logic        redirectValid;
    logic [31:0] redirectAddress;
    logic        memRequest;
    logic [31:0] memAddress;
    logic        memReady;
    logic        memDataValid;
    logic [31:0] memData;
    logic        fetchValid;
    logic [31:0] fetchInstruction;
    logic [31:0] fetchProgramCounter;
    logic        fetchReady;
    logic        protocolError;

    imem_prefetch_queue #(.DEPTH(DEPTH), .RESET_VECTOR(32'h0000_0000)) dut (
        .clock              (clock),
        .reset              (reset),
        .redirectValid      (redirectValid),
        .redirectAddress    (redirectAddress),
        .memRequest         (memRequest),
        .memAddress         (memAddress),
        .memReady           (memReady),
        .memDataValid       (memDataValid),
        .memData            (memData),
        .fetchValid         (fetchValid),
        .fetchInstruction   (fetchInstruction),
        .fetchProgramCounter(fetchProgramCounter),
        .fetchReady         (fetchReady),
        .protocolError      (protocolError)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model: ordered queues of outstanding PCs and delivered words.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } fent_t;

    fent_t       filled[$];
    logic [31:0] outq[$];
    int          m_drop;
    logic [31:0] m_npc;
    bit          m_perr;

    typedef struct {
        logic        mdv;
        logic [31:0] md;
        logic        fr;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_fv;
        logic [31:0] exp_pc;
        logic [31:0] exp_ins;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic bit m_req();
        return reset && !redirectValid &&
               (filled.size() + outq.size() + m_drop < int'(DEPTH));
    endfunction

    function automatic bit m_fv();
        return reset && !redirectValid && (filled.size() > 0);
    endfunction

    task automatic model_clear();
        filled.delete();
        outq.delete();
        m_drop = 0;
        m_npc  = 32'h0;
        m_perr = 1'b0;
    endtask

    task automatic check_model();
        bit rq;
        bit fv;
        rq = m_req();
        fv = m_fv();
        chk("memRequest", 32'(memRequest), 32'(rq));
        if (rq) chk("memAddress", memAddress, m_npc);
        chk("fetchValid", 32'(fetchValid), 32'(fv));
        if (fv) begin
            chk("fetchPC", fetchProgramCounter, filled[0].pc);
            chk("fetchInstr", fetchInstruction, filled[0].ins);
        end
        chk("protocolError", 32'(protocolError), 32'(m_perr));
    endtask

    task automatic model_update();
        bit    rq;
        bit    fv;
        bit    do_fill;
        int    total;
        fent_t e;
        rq      = m_req();
        fv      = m_fv();
        do_fill = 1'b0;
        if (redirectValid) begin
            total = m_drop + outq.size();
            if (memDataValid) begin
                if (total > 0) total--;
                else m_perr = 1'b1;
            end
            m_drop = total;
            outq.delete();
            filled.delete();
            m_npc = {redirectAddress[31:2], 2'b00};
        end else begin
            if (memDataValid) begin
                if (m_drop > 0) m_drop--;
                else if (outq.size() > 0) begin
                    e.pc    = outq.pop_front();
                    e.ins   = memData;
                    do_fill = 1'b1;
                end else m_perr = 1'b1;
            end
            if (fv && fetchReady) void'(filled.pop_front());
            if (do_fill) filled.push_back(e);
            if (rq && memReady) begin
                outq.push_back(m_npc);
                m_npc = m_npc + 32'd4;
            end
        end
    endtask

    task automatic drive(input logic rv, input logic [31:0] ra, input logic mr,
                         input logic mdv, input logic [31:0] md, input logic fr);
        redirectValid   = rv;
        redirectAddress = ra;
        memReady        = mr;
        memDataValid    = mdv;
        memData         = md;
        fetchReady      = fr;
        #1;
    endtask

    task automatic advance();
        model_update();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic step(input logic rv, input logic [31:0] ra, input logic mr,
                        input logic mdv, input logic [31:0] md, input logic fr);
        drive(rv, ra, mr, mdv, md, fr);
        check_model();
        advance();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("rst_memRequest", 32'(memRequest), 32'h0);
        chk("rst_fetchValid", 32'(fetchValid), 32'h0);
        chk("rst_fetchInstr", fetchInstruction, 32'h0);
        chk("rst_fetchPC", fetchProgramCounter, 32'h0);
        chk("rst_protocolError", 32'(protocolError), 32'h0);
        model_clear();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        model_clear();
        reset = 1'b0;
        vecs[0]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h00, 1'b0, 32'h0,         32'h0};
        vecs[1]  = '{1'b1, 32'hA000_0000, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0,         32'h0};
        vecs[2]  = '{1'b1, 32'hA000_0001, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00,        32'hA000_0000};
        vecs[3]  = '{1'b1, 32'hA000_0002, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04,        32'hA000_0001};
        vecs[4]  = '{1'b1, 32'hA000_0003, 1'b0, 1'b1, 32'h10, 1'b1, 32'h08,        32'hA000_0002};
        vecs[5]  = '{1'b1, 32'hA000_0004, 1'b0, 1'b1, 32'h14, 1'b1, 32'h08,        32'hA000_0002};
        vecs[6]  = '{1'b1, 32'hA000_0005, 1'b0, 1'b0, 32'h00, 1'b1, 32'h08,        32'hA000_0002};
        vecs[7]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h00, 1'b1, 32'h08,        32'hA000_0002};
        vecs[8]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h00, 1'b1, 32'h08,        32'hA000_0002};
        vecs[9]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h18, 1'b1, 32'h0C,        32'hA000_0003};
        vecs[10] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h00, 1'b1, 32'h0C,        32'hA000_0003};
        vecs[11] = '{1'b1, 32'hA000_0006, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h10,        32'hA000_0004};

        do_reset();

        // Streaming with a one-cycle IMEM, then backpressure until full.
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 32'h0, 1'b1, vecs[i].mdv, vecs[i].md, vecs[i].fr);
            chk($sformatf("vec%0d_req", i), 32'(memRequest), 32'(vecs[i].exp_req));
            if (vecs[i].exp_req) chk($sformatf("vec%0d_addr", i), memAddress, vecs[i].exp_addr);
            chk($sformatf("vec%0d_fv", i), 32'(fetchValid), 32'(vecs[i].exp_fv));
            if (vecs[i].exp_fv) begin
                chk($sformatf("vec%0d_pc", i), fetchProgramCounter, vecs[i].exp_pc);
                chk($sformatf("vec%0d_ins", i), fetchInstruction, vecs[i].exp_ins);
            end
            advance();
        end

        // Redirect with three requests outstanding.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h0000_0103, 1'b1, 1'b0, 32'h0, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'hDEAD_0000, 1'b1);
        chk("redir_req", 32'(memRequest), 32'h1);
        chk("redir_addr", memAddress, 32'h0000_0100);
        check_model();
        advance();
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'hDEAD_0004, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'hDEAD_0008, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h1111_0100, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("redir_fv", 32'(fetchValid), 32'h1);
        chk("redir_pc", fetchProgramCounter, 32'h0000_0100);
        chk("redir_ins", fetchInstruction, 32'h1111_0100);
        advance();

        // Redirect coinciding with a response while the head is filled.
        do_reset();
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h5555_0000, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 32'h0000_0200, 1'b1, 1'b1, 32'h5555_0004, 1'b1);
        chk("same_fv", 32'(fetchValid), 32'h0);
        chk("same_req", 32'(memRequest), 32'h0);
        check_model();
        advance();
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h5555_0008, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h2222_0200, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("same_pc", fetchProgramCounter, 32'h0000_0200);
        chk("same_ins", fetchInstruction, 32'h2222_0200);
        check_model();
        advance();

        // Address wrap from the top of the address space.
        do_reset();
        step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("wrap_addr0", memAddress, 32'hFFFF_FFFC);
        advance();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("wrap_addr1", memAddress, 32'h0000_0000);
        check_model();
        advance();

        // Randomized traffic with a reset in the middle of a burst.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            logic        rv;
            logic        mdv;
            rv  = ($urandom_range(19) == 0);
            mdv = ((m_drop + outq.size()) > 0) && ($urandom_range(9) < 6);
            step(rv, $urandom, ($urandom_range(9) < 7), mdv, $urandom, ($urandom_range(9) < 6));
            if (n == 700) do_reset();
        end

        // Response with nothing outstanding sets a sticky error.
        do_reset();
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h7777_0000, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h8888_0000, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("perr_set", 32'(protocolError), 32'h1);
        chk("perr_ins", fetchInstruction, 32'h7777_0000);
        chk("perr_pc", fetchProgramCounter, 32'h0);
        advance();
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_prefetch_queue.md
Name: imem_prefetch_queue

Overview:
Instruction prefetch queue between instruction memory and the Fetch stage. Issues sequential word requests ahead of Fetch, accepts in-order responses of arbitrary latency, and presents instruction/PC pairs to Fetch through a valid/ready handshake. On a redirect (branch or trap) it flushes all buffered words and silently discards responses still in flight.

Parameters:
DEPTH, 4, queue slots and maximum in-flight requests (power of two, ≥2)
RESET_VECTOR, 32'h0000_0000, first fetch address after reset

Ports:
clock  input  1  core clock
reset  input  1  asynchronous, active-low reset
redirectValid  input  1  flush and restart at redirectAddress
redirectAddress  input  32  new fetch PC (bits [1:0] ignored)
memRequest  output  1  request valid to IMEM
memAddress  output  32  word-aligned request address
memReady  input  1  IMEM accepts request this cycle
memDataValid  input  1  in-order response valid
memData  input  32  response instruction word
fetchValid  output  1  head entry holds an instruction
fetchInstruction  output  32  head instruction
fetchProgramCounter  output  32  head PC
fetchReady  input  1  Fetch consumes head this cycle
protocolError  output  1  sticky: response received with nothing outstanding

Behaviour:
- Reset low (async): all slots invalid, head/tail/counters 0, nextPC=RESET_VECTOR, dropCount=0, memRequest=0, fetchValid=0, fetchInstruction=0, fetchProgramCounter=0, protocolError=0.
- Slot state: EMPTY → ALLOCATED (request accepted, PC stored) → FILLED (response written) → EMPTY (popped or flushed).
- Issue: memRequest = !redirectValid && (allocatedSlots + dropCount < DEPTH). memAddress = nextPC. On memRequest && memReady: allocate tail slot with PC=nextPC, tail++, nextPC += 4 (mod 2^32).
- memRequest/memAddress are combinational from registered state plus redirectValid. Held stable until accepted unless a redirect occurs.
- Response: on memDataValid, if dropCount>0 then dropCount-- and discard. Otherwise fill the oldest ALLOCATED slot. If no slot is ALLOCATED, set protocolError and ignore.
- Output: fetchValid = head slot FILLED && !redirectValid. On fetchValid && fetchReady: head++ and slot → EMPTY. Zero-cycle bypass is not provided: a response is visible on fetchValid in the cycle after memDataValid.
- Redirect (highest priority):
  - All slots → EMPTY; head=tail=0.
  - dropCount_next = dropCount + ALLOCATED-slot count, counted before any same-cycle response.
  - A same-cycle response is counted against dropCount as usual.
  - nextPC = {redirectAddress[31:2],2'b00}.
  - No request and no pop that cycle.
  - The first request at the new PC is made the following cycle (redirect-to-request latency 1).
- Invariant: allocatedSlots + dropCount ≤ DEPTH. dropCount is clog2(DEPTH)+1 bits.
- Full: all slots in use → memRequest=0. Empty: fetchValid=0. Simultaneous pop + issue + fill in one cycle is legal.
- Back-to-back redirects accumulate dropCount correctly. Reset mid-burst discards everything, including dropCount.

Optional Feature:
PREFETCH_STATS_EN. When defined, adds two output ports:
- statFlushCount (32-bit): counts redirect cycles.
- statDropCount (32-bit): counts discarded responses.

Both counters saturate at all-ones and reset to 0. When undefined, neither port nor counter exists and behaviour is otherwise identical.

Test Plan:
- Reset release, memReady=1, 1-cycle IMEM, fetchReady=1 → requests 0x0,0x4,0x8…; fetchValid pairs (0x0,word0),(0x4,word1) in order, steady one per cycle.
- fetchReady=0, DEPTH=4 → exactly 4 requests accepted, memRequest drops to 0; raise fetchReady → 0x10 requested after first pop.
- Redirect to 0x103 with 3 requests outstanding → next memAddress 0x100; the 3 stale responses are discarded; first fetchValid shows PC 0x100.
- Redirect in the same cycle as memDataValid and with head FILLED → no pop, that response is dropped, dropCount ends at outstanding-1.
- nextPC=0xFFFF_FFFC → following request address 0x0000_0000.
- memDataValid with nothing outstanding → protocolError=1 and stays set until reset; queue contents unchanged.
